// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result streamer: geometry of the output SRAM,
// byte width, FSM state encoding and the drain-length clamp helper.
package result_streamer_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int OUT_WIDTH  = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;

  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_SEND_LO = 3'd3,
    S_SEND_HI = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  // Requests larger than the SRAM are cut to the SRAM depth so the
  // read address never wraps within a drain.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    logic [ADDR_W:0] r;
    if (l > LEN_DEPTH) begin
      r = LEN_DEPTH;
    end else begin
      r = l;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_streamer.sv
// Drains the output SRAM word by word and streams each 16-bit word as two
// bytes (low byte first) over a valid/ready interface. All outputs are
// registered; the SRAM read port is driven only while a drain is active.
module result_streamer
  import result_streamer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_re,
  output logic [ADDR_W-1:0]     sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  state_t                 state_r;
  logic [ADDR_W:0]        len_r;
  logic [ADDR_W:0]        count_r;
  logic [OUT_WIDTH-1:0]   word_hi_r;
  logic [ADDR_W:0]        count_inc_s;

  assign count_inc_s = count_r + LEN_ONE;

  // Drain FSM with all interface outputs and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      sram_re        <= 1'b0;
      sram_raddr     <= ADDR_ZERO;
      data_out       <= {OUT_WIDTH{1'b0}};
      data_out_valid <= 1'b0;
      len_r          <= LEN_ZERO;
      count_r        <= LEN_ZERO;
      word_hi_r      <= {OUT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            len_r   <= clamp_len(len);
            count_r <= LEN_ZERO;
            if (len != LEN_ZERO) begin
              state_r    <= S_READ;
              sram_re    <= 1'b1;
              sram_raddr <= ADDR_ZERO;
            end else begin
              // Empty drain: report completion without touching the SRAM.
              state_r <= S_FIN;
              done    <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_READ: begin
          // The SRAM has sampled the request on this edge.
          sram_re <= 1'b0;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          word_hi_r      <= sram_rdata[DATA_WIDTH-1:OUT_WIDTH];
          data_out       <= sram_rdata[OUT_WIDTH-1:0];
          data_out_valid <= 1'b1;
          state_r        <= S_SEND_LO;
        end
        S_SEND_LO: begin
          if (data_out_ready) begin
            data_out <= word_hi_r;
            state_r  <= S_SEND_HI;
          end else begin
            state_r <= S_SEND_LO;
          end
        end
        S_SEND_HI: begin
          if (data_out_ready) begin
            count_r        <= count_inc_s;
            data_out_valid <= 1'b0;
            if (count_inc_s == len_r) begin
              state_r <= S_FIN;
              done    <= 1'b1;
            end else begin
              state_r    <= S_READ;
              sram_re    <= 1'b1;
              sram_raddr <= sram_raddr + ADDR_ONE;
            end
          end else begin
            state_r <= S_SEND_HI;
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r        <= S_IDLE;
          busy           <= 1'b0;
          done           <= 1'b0;
          sram_re        <= 1'b0;
          data_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
